// File: rtl/lif_array.sv
// Multi-channel leaky integrate-and-fire neuron array with a per-channel
// refractory FSM and a saturating aggregate spike counter.
module lif_array #(
    parameter int NUM_CH     = 2,
    parameter int WIDTH      = 8,
    parameter int SHIFT_W    = 3,
    parameter int REF_W      = 4,
    parameter int CNT_W      = 8,
    parameter int RESET_MODE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NUM_CH*WIDTH-1:0] current,
    input  logic [WIDTH-1:0]        threshold,
    input  logic [SHIFT_W-1:0]      leak_shift,
    input  logic [REF_W-1:0]        refrac_len,
    input  logic                    clr_count,
    output logic [NUM_CH*WIDTH-1:0] state,
    output logic [NUM_CH-1:0]       spike,
    output logic                    spike_any,
    output logic [CNT_W-1:0]        spike_count
);

    typedef enum logic {
        INTEGRATE  = 1'b0,
        REFRACTORY = 1'b1
    } ch_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ch_state_t        fsm_q   [NUM_CH];
    ch_state_t        fsm_d   [NUM_CH];
    logic [WIDTH-1:0] mem_q   [NUM_CH];
    logic [WIDTH-1:0] mem_d   [NUM_CH];
    logic [WIDTH-1:0] leak    [NUM_CH];
    logic [WIDTH:0]   sum     [NUM_CH];
    logic [WIDTH-1:0] sat_val [NUM_CH];
    logic [REF_W-1:0] ref_q   [NUM_CH];
    logic [REF_W-1:0] ref_d   [NUM_CH];
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] spike_d;
    logic [31:0]       pop;
    logic [32:0]       count_wide;
    logic [CNT_W-1:0]  count_d;

    // The extra top bit of sum catches overflow so it can clamp to all-ones.
    always_comb begin
        fire = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            leak[i]    = (leak_shift == '0) ? '0 : (mem_q[i] >> leak_shift);
            sum[i]     = {1'b0, mem_q[i]} - {1'b0, leak[i]}
                       + {1'b0, current[i*WIDTH +: WIDTH]};
            sat_val[i] = sum[i][WIDTH] ? '1 : sum[i][WIDTH-1:0];
            fire[i]    = (sat_val[i] >= threshold);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            fsm_d[i] = fsm_q[i];
            if (en) begin
                case (fsm_q[i])
                    INTEGRATE: begin
                        if (fire[i] && (refrac_len != '0)) fsm_d[i] = REFRACTORY;
                    end
                    REFRACTORY: begin
                        if (ref_q[i] <= REF_W'(1)) fsm_d[i] = INTEGRATE;
                    end
                    default: fsm_d[i] = INTEGRATE;
                endcase
            end
        end
    end

    always_comb begin
        spike_d = '0;
        pop     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mem_d[i] = mem_q[i];
            ref_d[i] = ref_q[i];
            if (en) begin
                case (fsm_q[i])
                    INTEGRATE: begin
                        if (fire[i]) begin
                            spike_d[i] = 1'b1;
                            mem_d[i]   = (RESET_MODE != 0) ? (sat_val[i] - threshold) : '0;
                            if (refrac_len != '0) ref_d[i] = refrac_len;
                        end else begin
                            mem_d[i] = sat_val[i];
                        end
                    end
                    REFRACTORY: begin
                        if (ref_q[i] != '0) ref_d[i] = ref_q[i] - REF_W'(1);
                    end
                    default: ref_d[i] = '0;
                endcase
            end
            pop = pop + 32'(spike_d[i]);
        end
        // Clear takes priority, so spikes landing in the same cycle are dropped.
        count_wide = 33'(spike_count) + {1'b0, pop};
        if (clr_count)
            count_d = '0;
        else if (count_wide > 33'(CNT_MAX))
            count_d = CNT_MAX;
        else
            count_d = count_wide[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                fsm_q[i] <= INTEGRATE;
                mem_q[i] <= '0;
                ref_q[i] <= '0;
            end
            spike       <= '0;
            spike_any   <= 1'b0;
            spike_count <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                fsm_q[i] <= fsm_d[i];
                mem_q[i] <= mem_d[i];
                ref_q[i] <= ref_d[i];
            end
            spike       <= spike_d;
            spike_any   <= |spike_d;
            spike_count <= count_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_state
        assign state[g*WIDTH +: WIDTH] = mem_q[g];
    end

endmodule
